program_run_ctrl: RTL and testbench
===================================

// Module: program_run_ctrl
// PURPOSE
//  Run controller between the top-level Start/Ack handshake and the fetch stage.
//  Each Start pulse launches the next stored program (P1, P2, P3, then wrap to P1).
//  It loads the PC with that program's entry address, enables execution, and waits for the decoder's Halt.
//  It then raises Ack and holds it until the next Start. It also reports per-program cycle count and a watchdog timeout.
// PARAMETERS
//  PC_W      10     program counter width
//  CNT_W     16     cycle counter width
//  NUM_PROG  3      number of stored programs; ProgSel wraps modulo NUM_PROG
//  TIMEOUT   50000  RUN cycles before forced stop (must be < 2**CNT_W)
// PORTS
//  Clk         in   1         system clock; all state updates on rising edge
//  Reset       in   1         synchronous, active-high
//  Start       in   1         launch request; acts on its rising edge only
//  Halt        in   1         decoder flag: the executing instruction is the done/halt op
//  Ack         out  1         program finished; level, held in DONE
//  PcLoad      out  1         one-cycle strobe: PC <= PcTarget
//  PcTarget    out  PC_W      entry address of the selected program
//  RunEn       out  1         PC advance / register-file + data-memory write enable
//  ProgSel     out  2         index of the current/next program (0..NUM_PROG-1)
//  CycleCount  out  CNT_W     RUN cycles of the current/last program
//  Timeout     out  1         last program ended by watchdog, not by Halt
// BEHAVIOUR
//  Reset values: state=IDLE, Ack=0, PcLoad=0, RunEn=0, ProgSel=0, CycleCount=0, Timeout=0, StartQ=0.
//  Reset mid-operation aborts any program and returns to these values; ProgSel returns to 0.
//  Start edge: StartRise = Start & ~StartQ, where StartQ is Start registered each cycle.
//  FSM (registered state; outputs decoded from state):
//   IDLE : all outputs idle. StartRise -> LOAD.
//   LOAD : PcLoad=1 for exactly 1 cycle; PcTarget=START_ADDR[ProgSel]; CycleCount<=0; Timeout<=0. -> ARM.
//   ARM  : waits while Start=1, so the program does not run during the load window. Start=0 -> RUN.
//   RUN  : RunEn=1; CycleCount increments each cycle.
//          Halt=1 -> DONE; the Halt cycle is counted.
//          Else CycleCount==TIMEOUT-1 -> DONE with Timeout<=1.
//   DONE : Ack=1, RunEn=0, CycleCount and Timeout held.
//          On entry: ProgSel <= (ProgSel==NUM_PROG-1) ? 0 : ProgSel+1.
//          StartRise -> LOAD; Ack deasserts in the same cycle as PcLoad.
//  Latency: StartRise at edge N gives PcLoad high in cycle N+1. RunEn rises 1 cycle after Start falls (min 2 cycles).
//  Halt in RUN at edge M gives Ack=1 and RunEn=0 from cycle M+1.
//  Boundary rules:
//   - Halt is ignored outside RUN.
//   - StartRise is ignored in LOAD/ARM/RUN (no restart mid-program).
//   - Halt and timeout in the same cycle: Halt wins, Timeout=0.
//   - Start already high at reset release does not launch; a fresh rising edge is required.
//   - CycleCount never wraps: the watchdog fires before saturation.
//   - ProgSel wraps 2 -> 0 after the third program.
// STRUCTURE
//  run_ctrl_pkg holds:
//   - typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DONE} run_state_t
//   - START_ADDR table: P1=10'd0, P2=10'd128, P3=10'd256
//   - shared PC_W
//  Sub-module start_edge_det: StartQ register plus the rise pulse; reused for any other level-to-pulse input.
//  The FSM, ProgSel counter and CycleCount/watchdog live in program_run_ctrl.
// TESTING
//  1. Reset 2 cycles, Start low.
//     -> Ack=0, RunEn=0, PcLoad=0, ProgSel=0, CycleCount=0 every cycle.
//  2. Start high 1 cycle, Halt pulsed 20 cycles after RunEn rises.
//     -> PcLoad 1 cycle with PcTarget=0; CycleCount=21; Ack=1; ProgSel=1; Timeout=0.
//  3. Three back-to-back launches.
//     -> PcTarget sequence 0, 128, 256; after the fourth launch PcTarget=0 (wrap).
//  4. Halt never asserted, TIMEOUT overridden to 100.
//     -> Ack after exactly 100 RUN cycles; Timeout=1; CycleCount=100.
//     Halt and timeout in the same cycle -> Timeout=0.
//  5. Start held high 5 cycles.
//     -> single PcLoad, ARM for the full hold, RunEn 1 cycle after Start falls.
//     Extra Start pulses during RUN -> no second PcLoad.
//  6. Reset asserted mid-RUN of P2.
//     -> next cycle all outputs at reset values; next Start loads PcTarget=0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the program run controller:
// FSM state encoding, PC width and the program entry-address table.
package run_ctrl_pkg;

    localparam int PC_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        DONE
    } run_state_t;

    // START_ADDR table: P1, P2, P3 entry addresses; unused selector codes fall back to P1.
    function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
        case (sel)
            2'd0:    start_addr = 10'd0;
            2'd1:    start_addr = 10'd128;
            2'd2:    start_addr = 10'd256;
            default: start_addr = 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/start_edge_det.sv
// Level-to-pulse converter: registers the input and flags its rising edge.
// A level already high when reset is released is not treated as an edge.
module start_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;
    logic r_primed;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_level_q <= 1'b0;
            r_primed  <= 1'b0;
        end else begin
            r_level_q <= i_level;
            r_primed  <= 1'b1;
        end
    end

    // r_primed masks the first post-reset cycle, when r_level_q has not yet seen the real input.
    assign o_rise = i_level & ~r_level_q & r_primed;

endmodule

// File: rtl/program_run_ctrl.sv
// Run controller: launches stored programs in rotation on each Start edge,
// loads the PC, enables execution until Halt or watchdog, then holds Ack.
module program_run_ctrl #(
    parameter int PC_W     = 10,
    parameter int CNT_W    = 16,
    parameter int NUM_PROG = 3,
    parameter int TIMEOUT  = 50000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             Ack,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcTarget,
    output logic             RunEn,
    output logic [1:0]       ProgSel,
    output logic [CNT_W-1:0] CycleCount,
    output logic             Timeout
);

    import run_ctrl_pkg::*;

    run_state_t       r_state;
    run_state_t       w_next_state;
    logic [1:0]       r_prog_sel;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_timeout;
    logic             w_start_rise;
    logic             w_watchdog_hit;

    start_edge_det u_start_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (Start),
        .o_rise  (w_start_rise)
    );

    assign w_watchdog_hit = (r_cycle_count == CNT_W'(TIMEOUT - 1));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        Ack          = 1'b0;
        PcLoad       = 1'b0;
        RunEn        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise) w_next_state = LOAD;
            end
            LOAD: begin
                PcLoad       = 1'b1;
                w_next_state = ARM;
            end
            ARM: begin
                if (!Start) w_next_state = RUN;
            end
            RUN: begin
                RunEn = 1'b1;
                if (Halt || w_watchdog_hit) w_next_state = DONE;
            end
            DONE: begin
                Ack = 1'b1;
                if (w_start_rise) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_prog_sel    <= 2'd0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                LOAD: begin
                    r_cycle_count <= '0;
                    r_timeout     <= 1'b0;
                end
                RUN: begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                    // Halt takes priority over the watchdog in the same cycle.
                    if (Halt || w_watchdog_hit) begin
                        r_timeout  <= ~Halt;
                        r_prog_sel <= (r_prog_sel == 2'(NUM_PROG - 1)) ? 2'd0 : r_prog_sel + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PcTarget   = PC_W'(start_addr(r_prog_sel));
    assign ProgSel    = r_prog_sel;
    assign CycleCount = r_cycle_count;
    assign Timeout    = r_timeout;

endmodule

// File: tb/tb_program_run_ctrl.sv
// Directed self-checking bench for program_run_ctrl with the watchdog shortened to 100 cycles.
module tb_program_run_ctrl;

    localparam int PC_W    = 10;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic             Halt;
    logic             Ack;
    logic             PcLoad;
    logic [PC_W-1:0]  PcTarget;
    logic             RunEn;
    logic [1:0]       ProgSel;
    logic [CNT_W-1:0] CycleCount;
    logic             Timeout;

    int errors = 0;
    int checks = 0;

    program_run_ctrl #(
        .PC_W     (PC_W),
        .CNT_W    (CNT_W),
        .NUM_PROG (3),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Ack        (Ack),
        .PcLoad     (PcLoad),
        .PcTarget   (PcTarget),
        .RunEn      (RunEn),
        .ProgSel    (ProgSel),
        .CycleCount (CycleCount),
        .Timeout    (Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ack"},   32'(Ack),        32'd0);
        chk({tag, "_runen"}, 32'(RunEn),      32'd0);
        chk({tag, "_pcld"},  32'(PcLoad),     32'd0);
        chk({tag, "_sel"},   32'(ProgSel),    32'd0);
        chk({tag, "_cnt"},   32'(CycleCount), 32'd0);
        chk({tag, "_tmo"},   32'(Timeout),    32'd0);
    endtask

    // One full launch ending in Halt during RUN cycle run_cycles (1-based).
    task automatic run_prog(input string tag, input int exp_tgt, input int exp_sel, input int run_cycles);
        Start = 1'b1;
        step();
        chk({tag, "_load_pcld"}, 32'(PcLoad),   32'd1);
        chk({tag, "_load_tgt"},  32'(PcTarget), 32'(exp_tgt));
        chk({tag, "_load_ack"},  32'(Ack),      32'd0);
        Start = 1'b0;
        step();
        chk({tag, "_arm_pcld"},  32'(PcLoad),   32'd0);
        chk({tag, "_arm_runen"}, 32'(RunEn),    32'd0);
        step();
        chk({tag, "_run_runen"}, 32'(RunEn),      32'd1);
        chk({tag, "_run_cnt0"},  32'(CycleCount), 32'd0);
        repeat (run_cycles - 1) step();
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        chk({tag, "_done_ack"},   32'(Ack),        32'd1);
        chk({tag, "_done_runen"}, 32'(RunEn),      32'd0);
        chk({tag, "_done_cnt"},   32'(CycleCount), 32'(run_cycles));
        chk({tag, "_done_sel"},   32'(ProgSel),    32'(exp_sel));
        chk({tag, "_done_tmo"},   32'(Timeout),    32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Halt  = 1'b0;

        // Reset for two cycles, outputs idle every cycle.
        step();
        chk_idle("rst_c1");
        step();
        chk_idle("rst_c2");
        Reset = 1'b0;
        step();
        chk_idle("post_rst");

        // Halt outside RUN has no effect.
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        chk_idle("halt_idle");

        // P1: Halt in the 21st RUN cycle gives CycleCount=21.
        run_prog("p1", 0, 1, 21);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        chk("done_halt_ack", 32'(Ack),        32'd1);
        chk("done_halt_cnt", 32'(CycleCount), 32'd21);

        // Back-to-back launches: P2, P3, then wrap to P1.
        run_prog("p2", 128, 2, 3);
        run_prog("p3", 256, 0, 1);
        run_prog("p1w", 0, 1, 5);

        // Watchdog: P2 with no Halt stops after exactly 100 RUN cycles.
        Start = 1'b1;
        step();
        chk("wd_load_tgt", 32'(PcTarget), 32'd128);
        Start = 1'b0;
        step();
        step();
        repeat (99) step();
        chk("wd_c100_runen", 32'(RunEn),      32'd1);
        chk("wd_c100_cnt",   32'(CycleCount), 32'd99);
        chk("wd_c100_ack",   32'(Ack),        32'd0);
        step();
        chk("wd_done_ack",   32'(Ack),        32'd1);
        chk("wd_done_runen", 32'(RunEn),      32'd0);
        chk("wd_done_tmo",   32'(Timeout),    32'd1);
        chk("wd_done_cnt",   32'(CycleCount), 32'd100);
        chk("wd_done_sel",   32'(ProgSel),    32'd2);

        // Halt coinciding with the watchdog cycle: Halt wins, Timeout clears.
        run_prog("wd_halt", 256, 0, 100);

        // Start held high for 5 cycles: one PcLoad, ARM for the full hold.
        Start = 1'b1;
        step();
        chk("hold_load_pcld", 32'(PcLoad),   32'd1);
        chk("hold_load_tgt",  32'(PcTarget), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hold_arm%0d_pcld", i),  32'(PcLoad), 32'd0);
            chk($sformatf("hold_arm%0d_runen", i), 32'(RunEn),  32'd0);
        end
        Start = 1'b0;
        step();
        chk("hold_run_runen", 32'(RunEn), 32'd1);

        // Start pulse during RUN is ignored.
        Start = 1'b1;
        step();
        chk("midrun_pcld",  32'(PcLoad), 32'd0);
        chk("midrun_runen", 32'(RunEn),  32'd1);
        Start = 1'b0;
        step();
        chk("midrun2_pcld", 32'(PcLoad), 32'd0);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        chk("hold_done_ack", 32'(Ack),        32'd1);
        chk("hold_done_cnt", 32'(CycleCount), 32'd3);
        chk("hold_done_sel", 32'(ProgSel),    32'd1);

        // Reset mid-RUN of P2, with Start held high across reset release.
        Start = 1'b1;
        step();
        chk("p2r_load_tgt", 32'(PcTarget), 32'd128);
        Start = 1'b0;
        step();
        step();
        repeat (4) step();
        chk("p2r_running", 32'(RunEn), 32'd1);
        Start = 1'b1;
        Reset = 1'b1;
        step();
        chk_idle("midrun_rst");
        Reset = 1'b0;
        step();
        chk("rel_high_pcld", 32'(PcLoad), 32'd0);
        step();
        chk("rel_high2_pcld", 32'(PcLoad), 32'd0);
        chk("rel_high2_ack",  32'(Ack),    32'd0);
        Start = 1'b0;
        step();
        run_prog("after_rst", 0, 1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
